// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execute stage: ALU opcodes, shifter codes,
// NZCV bit positions and forwarding select codes.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_t;

    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    // Rotate right by 0..31 through a doubled word so no amount needs a special case.
    function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
        logic [63:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[31:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator: memory offset, rotated 8-bit immediate, or
// immediate-shifted register value.
module val2_gen
    import arm_pkg::*;
(
    input  logic [31:0] res2,
    input  logic [11:0] shift_operand,
    input  logic        is_imm,
    input  logic        mem_inst,
    output logic [31:0] val2
);

    logic [4:0] shamt_s;
    logic [4:0] rot_s;

    assign shamt_s = shift_operand[11:7];
    assign rot_s   = {shift_operand[11:8], 1'b0};

    // Select the operand source; bit 4 (register-specified shift) is ignored.
    always_comb begin
        val2 = 32'h0000_0000;
        if (mem_inst) begin
            val2 = {20'h0_0000, shift_operand};
        end else if (is_imm) begin
            val2 = ror32({24'h00_0000, shift_operand[7:0]}, rot_s);
        end else begin
            case (shift_operand[6:5])
                SHIFT_LSL: val2 = res2 << shamt_s;
                SHIFT_LSR: val2 = res2 >> shamt_s;
                SHIFT_ASR: val2 = $unsigned($signed(res2) >>> shamt_s);
                SHIFT_ROR: val2 = ror32(res2, shamt_s);
                default:   val2 = res2;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2, ALU, branch target, NZCV status and EX/MEM register.
// Optional operand forwarding is enabled with `define EXE_FORWARDING_EN.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  S_UpdateSig,
    input  logic                  branch,
    input  logic                  memWriteEn,
    input  logic                  memReadEn,
    input  logic                  writeBackEn,
    input  logic [3:0]            exeCMD,
    input  logic [DATA_W-1:0]     res1,
    input  logic [DATA_W-1:0]     res2,
    input  logic [DATA_W-1:0]     PC,
    input  logic [23:0]           signedImm24,
    input  logic [REG_ADDR_W-1:0] R_d,
    input  logic                  isImmidiate,
    input  logic [11:0]           shiftOperand,
    input  logic                  carry,
`ifdef EXE_FORWARDING_EN
    input  logic [1:0]            selSrc1,
    input  logic [1:0]            selSrc2,
    input  logic [DATA_W-1:0]     memFwdVal,
    input  logic [DATA_W-1:0]     wbFwdVal,
`endif
    output logic                  branchTaken,
    output logic [DATA_W-1:0]     branchAddr,
    output logic [3:0]            status,
    output logic                  wbEnOut,
    output logic                  memREnOut,
    output logic                  memWEnOut,
    output logic [DATA_W-1:0]     aluResOut,
    output logic [DATA_W-1:0]     stValOut,
    output logic [REG_ADDR_W-1:0] destOut
);

    logic [31:0]           op1_s;
    logic [31:0]           op2_s;
    logic [31:0]           val2_s;
    logic                  mem_inst_s;
    logic [31:0]           add_b_s;
    logic                  add_cin_s;
    logic                  is_arith_s;
    logic                  is_valid_s;
    logic [31:0]           logic_res_s;
    logic [32:0]           sum_s;
    logic [31:0]           alu_res_s;
    logic [3:0]            flags_s;

    logic [3:0]            status_d,    status_q;
    logic                  wb_en_d,     wb_en_q;
    logic                  mem_r_en_d,  mem_r_en_q;
    logic                  mem_w_en_d,  mem_w_en_q;
    logic [31:0]           alu_res_d,   alu_res_q;
    logic [31:0]           st_val_d,    st_val_q;
    logic [REG_ADDR_W-1:0] dest_d,      dest_q;

`ifdef EXE_FORWARDING_EN
    // Forwarding muxes; both 00 and 11 fall back to the register file value.
    always_comb begin
        case (selSrc1)
            FWD_MEM: op1_s = memFwdVal;
            FWD_WB:  op1_s = wbFwdVal;
            default: op1_s = res1;
        endcase
        case (selSrc2)
            FWD_MEM: op2_s = memFwdVal;
            FWD_WB:  op2_s = wbFwdVal;
            default: op2_s = res2;
        endcase
    end
`else
    assign op1_s = res1;
    assign op2_s = res2;
`endif

    assign mem_inst_s = memReadEn | memWriteEn;

    val2_gen u_val2_gen (
        .res2          (op2_s),
        .shift_operand (shiftOperand),
        .is_imm        (isImmidiate),
        .mem_inst      (mem_inst_s),
        .val2          (val2_s)
    );

    // Opcode decode: subtraction is folded into the adder as op1 + ~val2 + cin.
    always_comb begin
        add_b_s     = val2_s;
        add_cin_s   = 1'b0;
        is_arith_s  = 1'b0;
        is_valid_s  = 1'b1;
        logic_res_s = 32'h0000_0000;
        case (exeCMD)
            EXE_MOV: logic_res_s = val2_s;
            EXE_MVN: logic_res_s = ~val2_s;
            EXE_ADD: is_arith_s = 1'b1;
            EXE_ADC: begin
                is_arith_s = 1'b1;
                add_cin_s  = carry;
            end
            EXE_SUB: begin
                is_arith_s = 1'b1;
                add_b_s    = ~val2_s;
                add_cin_s  = 1'b1;
            end
            EXE_SBC: begin
                is_arith_s = 1'b1;
                add_b_s    = ~val2_s;
                add_cin_s  = carry;
            end
            EXE_AND: logic_res_s = op1_s & val2_s;
            EXE_ORR: logic_res_s = op1_s | val2_s;
            EXE_EOR: logic_res_s = op1_s ^ val2_s;
            default: is_valid_s = 1'b0;
        endcase
    end

    assign sum_s     = {1'b0, op1_s} + {1'b0, add_b_s} + {32'h0000_0000, add_cin_s};
    assign alu_res_s = is_arith_s ? sum_s[31:0] : logic_res_s;

    // Logical ops and moves keep C and V from the current status.
    always_comb begin
        flags_s[STATUS_N] = alu_res_s[31];
        flags_s[STATUS_Z] = (alu_res_s == 32'h0000_0000);
        if (is_arith_s) begin
            flags_s[STATUS_C] = sum_s[32];
            flags_s[STATUS_V] = (op1_s[31] == add_b_s[31]) && (alu_res_s[31] != op1_s[31]);
        end else begin
            flags_s[STATUS_C] = status_q[STATUS_C];
            flags_s[STATUS_V] = status_q[STATUS_V];
        end
    end

    // Next-state of EX/MEM and status: freeze holds everything.
    always_comb begin
        status_d   = status_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        alu_res_d  = alu_res_q;
        st_val_d   = st_val_q;
        dest_d     = dest_q;
        if (!freeze) begin
            wb_en_d    = writeBackEn;
            mem_r_en_d = memReadEn;
            mem_w_en_d = memWriteEn;
            alu_res_d  = alu_res_s;
            st_val_d   = op2_s;
            dest_d     = R_d;
            if (S_UpdateSig && is_valid_s) begin
                status_d = flags_s;
            end else begin
                status_d = status_q;
            end
        end else begin
            status_d = status_q;
        end
    end

    // EX/MEM and status registers; reset overrides freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= 4'b0000;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= 32'h0000_0000;
            st_val_q   <= 32'h0000_0000;
            dest_q     <= {REG_ADDR_W{1'b0}};
        end else begin
            status_q   <= status_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
        end
    end

    assign branchTaken = branch;
    assign branchAddr  = PC + {{6{signedImm24[23]}}, signedImm24, 2'b00};

    assign status    = status_q;
    assign wbEnOut   = wb_en_q;
    assign memREnOut = mem_r_en_q;
    assign memWEnOut = mem_w_en_q;
    assign aluResOut = alu_res_q;
    assign stValOut  = st_val_q;
    assign destOut   = dest_q;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline.
- Consumes the ID/EX register outputs and generates the second operand (Val2).
- Runs the ALU, computes the branch target and owns the NZCV status register.
- Registers its results into the EX/MEM boundary for the memory stage.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- REG_ADDR_W, 4, destination register index width.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- freeze, in, 1: memory-stage wait. Holds the EX/MEM register and status register.
- S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn, in, 1 each: control from ID/EX.
- exeCMD, in, 4: ALU opcode.
- res1, res2, in, 32: Rn and Rm/Rd register values.
- PC, in, 32: instruction address + 4.
- signedImm24, in, 24: branch offset.
- R_d, in, 4: destination register.
- isImmidiate, in, 1: I bit.
- shiftOperand, in, 12: shifter operand field.
- carry, in, 1: C flag sampled at decode, used by ADC/SBC.
- branchTaken, out, 1: combinational, equals branch. Redirects IF and flushes IF/ID and ID/EX.
- branchAddr, out, 32: combinational branch target.
- status, out, 4: registered {N,Z,C,V}, fed to ID condition check.
- wbEnOut, memREnOut, memWEnOut, out, 1 each: registered control.
- aluResOut, out, 32: registered ALU result or memory address.
- stValOut, out, 32: registered store data (res2).
- destOut, out, 4: registered R_d.

Behaviour:
- Reset: synchronous. On a clk edge with rst=1, every registered output and status clear to 0. rst has priority over freeze.
- Latency: one cycle. Inputs at edge k produce EX/MEM outputs and status valid after edge k+1.
- freeze=1: all EX/MEM outputs and status hold their values.
- branchTaken and branchAddr stay combinational regardless of freeze.
- Val2 source selection:
  - memReadEn|memWriteEn: zero-extended shiftOperand[11:0].
  - isImmidiate: {24'b0,shiftOperand[7:0]} rotated right by 2*shiftOperand[11:8].
  - otherwise: res2 shifted by shiftOperand[11:7], type shiftOperand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - Shift amount 0 gives res2 unchanged. No RRX. Register-specified shift (bit4) is not supported; it is treated as an immediate shift.
- exeCMD encoding:
  - 0001 MOV: result = Val2.
  - 1001 MVN: result = ~Val2.
  - 0010 ADD/LDR/STR: res1+Val2.
  - 0011 ADC: res1+Val2+carry.
  - 0100 SUB/CMP: res1-Val2.
  - 0101 SBC: res1-Val2-!carry.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags unchanged.
- Flags:
  - N=result[31]; Z=(result==0).
  - Arithmetic ops: C is the 33rd bit of a+b+cin. Subtract is computed as res1+~Val2+cin, so C=1 means no borrow. V is signed overflow.
  - Logical ops and MOV/MVN: C and V keep their current status values.
- Status write: at an edge when S_UpdateSig=1, freeze=0 and rst=0.
- Branch target: branchAddr = PC + sign-extended(signedImm24)<<2, modulo 2^32 (wraps).
- Bubble: an all-zero ID/EX input (flushed) must propagate as wbEn=memREn=memWEn=0 with no status change.

Optional Feature:
EXE_FORWARDING_EN
- Defined: adds ports selSrc1, selSrc2 (in, 2 each: 00 reg, 01 memFwdVal, 10 wbFwdVal, 11 reg), memFwdVal and wbFwdVal (in, 32). The chosen values replace res1 and res2 before Val2 generation and the ALU; the forwarded res2 also becomes stValOut.
- Undefined: the ports are absent and res1/res2 are used directly. The hazard unit must stall instead of forwarding.

Decomposition:
- Package arm_pkg holds:
  - exeCMD localparams.
  - Shift type codes.
  - Status bit indices N=3, Z=2, C=1, V=0.
  - Forward-select codes.
- Sub-module val2_gen: combinational shifter/rotator with inputs res2, shiftOperand, isImmidiate and memory-instruction flag.
- The ALU stays inline.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs 0, status=0000.
- ADD: res1=0x7FFFFFFF, immediate Val2=1, S=1 -> aluResOut=0x80000000, status N=1 Z=0 C=0 V=1.
- SUB: res1=5, res2=5, shift 0, S=1 -> result 0, status 0110. Then MOV imm 0xFF rot 4 (0xF000000F) with S=1 -> result 0xF000000F, N=1, C stays 1.
- LDR: res1=0x100, shiftOperand=0xFFC, memReadEn=1, writeBackEn=1 -> aluResOut=0x10FC, memREnOut=1, status unchanged.
- Branch: PC=0x20, signedImm24=0xFFFFFE -> branchTaken=1, branchAddr=0x18. PC=0xFFFFFFFC, imm=1 -> branchAddr=0x0.
- freeze=1 for 3 cycles with an S-setting ADD presented -> outputs and status hold; freeze released -> update on next edge. Assert rst during freeze -> outputs clear.
